// File: rtl/ma_decimator_pkg.sv
// Shared defaults and sample type for the moving-average decimator slice.
package ma_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DECIM_LOG2 = 3;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/ma_decimator_fifo.sv
// First-word-fall-through FIFO; read data holds the last head value while empty.
module ma_sync_fifo
    import ma_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] last_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
    assign do_push  = push && (!full || do_pop);
    assign last_ptr = rd_ptr - PTR_W'(1);
    assign rd_data  = empty ? mem[last_ptr] : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/ma_decimator.sv
// Block-average decimator by 2**DECIM_LOG2 feeding an output FIFO.
// Define MA_DECIM_ROUND_EN for round-half-up results instead of floor.
module ma_decimator
    import ma_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DECIM_LOG2 = DEF_DECIM_LOG2,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         ovf_sticky,
    input  logic                         ovf_clr
);

    localparam int ACC_W = DATA_WIDTH + DECIM_LOG2;

    logic [DECIM_LOG2-1:0] phase;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      in_ext;
    logic [DATA_WIDTH-1:0] result;
    logic                  dump;
    logic                  pop;
    logic                  full;
    logic                  empty;

    assign in_ext = ACC_W'(in_data);
    assign dump   = in_valid && (phase == '1);
    assign pop    = out_valid && out_ready;

`ifdef MA_DECIM_ROUND_EN
    localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (DECIM_LOG2 - 1);
    assign result = DATA_WIDTH'(({1'b0, acc} + {1'b0, in_ext} + HALF) >> DECIM_LOG2);
`else
    assign result = DATA_WIDTH'((acc + in_ext) >> DECIM_LOG2);
`endif

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            phase <= '0;
            acc   <= '0;
        end else if (in_valid) begin
            phase <= phase + DECIM_LOG2'(1);
            acc   <= dump ? '0 : acc + in_ext;
        end
    end

    // Set wins over clear when a result is dropped in the clearing cycle.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            ovf_sticky <= 1'b0;
        end else if (dump && full && !pop) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

    ma_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (dump),
        .pop     (pop),
        .wr_data (result),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_ma_decimator.sv
// Directed self-checking bench for ma_decimator with default parameters.
module tb_ma_decimator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fifo_level;
    logic        ovf_sticky;
    logic        ovf_clr;

    int checks = 0;
    int failures = 0;
    int seen;
    logic [15:0] last_val;

    ma_decimator #(
        .DATA_WIDTH (16),
        .DECIM_LOG2 (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [15:0] d);
        for (int i = 0; i < 8; i++) send(d);
    endtask

    initial begin
        reset_n   = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        step();
        step();
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_ovf", ovf_sticky, 0);
        reset_n = 1'b0;
        step();

        // 8 x 100, consumer ready
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(16'd100);
            check_eq("early_valid", out_valid, 0);
        end
        send(16'd100);
        check_eq("blk100_valid", out_valid, 1);
        check_eq("blk100_data", out_data, 100);
        check_eq("blk100_level", fifo_level, 1);
        step();
        check_eq("blk100_pulse", out_valid, 0);
        check_eq("hold_last", out_data, 100);
        step();
        check_eq("ready_empty_level", fifo_level, 0);

        // 0..7, sum 28
        for (int i = 0; i < 8; i++) send(16'(i));
        check_eq("ramp_valid", out_valid, 1);
`ifdef MA_DECIM_ROUND_EN
        check_eq("ramp_data", out_data, 4);
`else
        check_eq("ramp_data", out_data, 3);
`endif
        step();

        // valid every other cycle, 16 samples of 0xFFFF
        seen = 0;
        last_val = '0;
        for (int i = 0; i < 32; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 16'hFFFF;
            step();
            if (out_valid) begin
                seen++;
                last_val = out_data;
            end
        end
        in_valid = 1'b0;
        check_eq("sparse_count", seen, 2);
        check_eq("sparse_data", last_val, 16'hFFFF);

        // 5 blocks with consumer stalled; set wins over clear on the drop
        out_ready = 1'b0;
        for (int b = 1; b <= 4; b++) send_block(16'(b * 10));
        check_eq("full_level4", fifo_level, 4);
        check_eq("full_no_ovf", ovf_sticky, 0);
        for (int i = 0; i < 7; i++) send(16'd50);
        ovf_clr = 1'b1;
        send(16'd50);
        ovf_clr = 1'b0;
        check_eq("ovf_set", ovf_sticky, 1);
        check_eq("ovf_level", fifo_level, 4);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_eq("drain_data", out_data, 32'(k * 10));
            step();
        end
        out_ready = 1'b0;
        check_eq("drain_empty", out_valid, 0);
        check_eq("drain_hold", out_data, 40);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_eq("ovf_clr", ovf_sticky, 0);

        // full FIFO, dump coincides with pop
        for (int b = 1; b <= 4; b++) send_block(16'(b));
        for (int i = 0; i < 7; i++) send(16'd5);
        out_ready = 1'b1;
        send(16'd5);
        out_ready = 1'b0;
        check_eq("simul_level", fifo_level, 4);
        check_eq("simul_ovf", ovf_sticky, 0);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check_eq("simul_drain", out_data, 32'(k));
            step();
        end
        check_eq("simul_empty", out_valid, 0);

        // reset mid-block discards partial sum
        for (int i = 0; i < 5; i++) send(16'd77);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        check_eq("async_rst_data", out_data, 0);
        reset_n = 1'b0;
        step();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'd10);
            if (out_valid) begin
                seen++;
                last_val = out_data;
            end
        end
        step();
        check_eq("post_rst_count", seen, 1);
        check_eq("post_rst_data", last_val, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ma_decimator.md
MA_DECIMATOR -- requirements
Module: ma_decimator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: unsigned sample width, matching the moving-average output.
REQ-002 The block SHALL have parameter DECIM_LOG2, default 3: decimation factor is 2**DECIM_LOG2; legal range 1..8.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries; power of 2, minimum 2.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_data, input, DATA_WIDTH bits: filtered sample from the upstream moving-average stage.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle; there is no back-pressure upstream.
REQ-008 The block SHALL have port out_data, output, DATA_WIDTH bits: decimated sample at the FIFO head.
REQ-009 The block SHALL have port out_valid, output, 1 bit: FIFO not empty.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts; a pop occurs when out_valid && out_ready.
REQ-011 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-012 The block SHALL have port ovf_sticky, output, 1 bit: a decimated result was dropped because the FIFO was full.
REQ-013 The block SHALL have port ovf_clr, input, 1 bit: synchronous clear of ovf_sticky.

Function
REQ-014 The block SHALL hold a phase counter, DECIM_LOG2 bits, incremented modulo 2**DECIM_LOG2 on each in_valid cycle and held when in_valid is low.
REQ-015 The block SHALL hold an accumulator, DATA_WIDTH+DECIM_LOG2 bits, unsigned: acc <= acc + in_data on each in_valid cycle where phase != max.
REQ-016 On an in_valid cycle with phase == max (the dump cycle), the block SHALL compute total = acc + in_data, load result = total >> DECIM_LOG2 (floor), and set acc <= 0.
REQ-017 The result from REQ-016 SHALL be written to the FIFO on that same clock edge; out_valid SHALL rise on the next cycle if the FIFO was empty, giving 1-cycle latency.
REQ-018 The FIFO SHALL be first-word-fall-through: out_data SHALL equal the head entry whenever out_valid = 1, and SHALL hold the last head value when the FIFO is empty.
REQ-019 A push and a pop in the same cycle SHALL both take effect, leaving fifo_level unchanged; this SHALL hold even when the FIFO is full.
REQ-020 A push when the FIFO is full with no pop in the same cycle SHALL drop the new result, leave the FIFO contents unchanged, and set ovf_sticky.
REQ-021 ovf_sticky SHALL clear on ovf_clr; if a drop and ovf_clr occur in the same cycle, set SHALL win.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL range 0..FIFO_DEPTH inclusive.
REQ-023 out_ready while out_valid = 0 SHALL have no effect.

Reset
REQ-024 While reset_n = 1, asynchronously: phase = 0, acc = 0, FIFO empty, fifo_level = 0, out_valid = 0, out_data = 0, ovf_sticky = 0.
REQ-025 Reset mid-block SHALL discard the partial accumulation; the first in_valid after release SHALL be phase 0.

Configuration
REQ-026 Macro MA_DECIM_ROUND_EN defined: result SHALL be (total + 2**(DECIM_LOG2-1)) >> DECIM_LOG2 (round-half-up), computed with one extra intermediate bit; the result cannot exceed 2**DATA_WIDTH-1, so no saturation logic is needed.
REQ-027 Macro MA_DECIM_ROUND_EN undefined: result SHALL be floor truncation per REQ-016, with no rounding adder present.

Structure
REQ-028 Shared package ma_pkg SHALL hold the default DATA_WIDTH, DECIM_LOG2 and FIFO_DEPTH constants and the sample typedef, unsigned logic [DATA_WIDTH-1:0].
REQ-029 The FIFO SHALL be a separate sub-module ma_sync_fifo (push, pop, full, empty, level), instantiated once.

Verification
REQ-030 DECIM_LOG2=3, 8 consecutive in_data=100, out_ready=1 -> out_valid pulses for one cycle, out_data=100, 1 cycle after the 8th sample edge.
REQ-031 Inputs 0,1,2..7 (sum 28) -> out_data=3 without the macro; out_data=4 with MA_DECIM_ROUND_EN.
REQ-032 in_valid toggling every other cycle over 16 samples of 0xFFFF -> exactly 2 outputs of 0xFFFF; phase does not advance on idle cycles.
REQ-033 out_ready=0, 5 blocks, FIFO_DEPTH=4 -> fifo_level=4, ovf_sticky=1, the 5th result dropped; then out_ready=1 drains the 4 results in order.
REQ-034 FIFO full, dump cycle coinciding with a pop -> no drop, ovf_sticky stays 0, fifo_level stays 4.
REQ-035 reset_n pulsed after 5 of 8 samples, then 8 samples of 10 -> single output of 10; no residue from the discarded partial accumulation.
